fx_share_ctrl: RTL and testbench



---
 rtl/fx_share_pkg.sv | 18 +
 rtl/fx_share_ctrl_if.sv | 32 +++
 rtl/fx_share_ctrl_rr_arbiter.sv | 28 ++
 rtl/fx_share_ctrl.sv | 157 +++++++++++++++
 tb/tb_fx_share_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_share_pkg.sv
// Shared types and constants for the fx_opt sharing controller.
// Holds the scheduler state encoding, the abort result value and parameter defaults.
package fx_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fx_state_e;

    // Quiet NaN returned to a requester whose core request was aborted
    localparam logic [31:0] FX_NAN = 32'h7FC00000;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 64;

endpackage

// File: rtl/fx_share_ctrl_if.sv
// Custom-instruction handshake between the sharing controller and one fx_opt core.
// master = controller side, slave = core side.
interface fx_share_ctrl_if #(
    parameter int unsigned DATA_W = 32
);

    logic              core_start;
    logic [DATA_W-1:0] core_x;
    logic              core_clk_en;
    logic              core_reset;
    logic              core_done;
    logic [DATA_W-1:0] core_f_x;

    modport master (
        output core_start,
        output core_x,
        output core_clk_en,
        output core_reset,
        input  core_done,
        input  core_f_x
    );

    modport slave (
        input  core_start,
        input  core_x,
        input  core_clk_en,
        input  core_reset,
        output core_done,
        output core_f_x
    );

endinterface

// File: rtl/fx_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first pending index after last_grant,
// wrapping, as a one-hot vector.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic             any_valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % N_REQ);
            if (!any_valid && pending[idx]) begin
                grant[idx] = 1'b1;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fx_share_ctrl.sv
// Round-robin sharing of one multi-cycle fx_opt core between N_REQ custom-instruction
// requesters, with one buffered operand per requester and a WAIT watchdog.
module fx_share_ctrl
    import fx_share_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic [N_REQ-1:0]             req_start,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_x,
    output logic [N_REQ-1:0]             req_done,
    output logic [DATA_W-1:0]            f_x,
    output logic [N_REQ-1:0]             req_err,
    output logic                         timeout_flag,
    fx_share_ctrl_if.master              core
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    fx_state_e                    state;
    logic [N_REQ-1:0]             pending;
    logic [N_REQ-1:0][DATA_W-1:0] xbuf;
    logic [IDX_W-1:0]             owner;
    logic [IDX_W-1:0]             last_grant;
    logic [WD_W-1:0]              wd;

    logic [DATA_W-1:0]            core_x_r;
    logic                         core_start_r;
    logic                         abort_r;
    logic [N_REQ-1:0]             req_done_r;
    logic [DATA_W-1:0]            f_x_r;
    logic [N_REQ-1:0]             req_err_r;
    logic                         tflag_r;

    logic [N_REQ-1:0]             grant;
    logic                         any_valid;
    logic                         do_grant;
    logic [IDX_W-1:0]             grant_idx;
    logic [N_REQ-1:0]             busy;
    logic [N_REQ-1:0]             accept;
    logic [N_REQ-1:0]             pending_nxt;
    logic [N_REQ-1:0]             owner_oh;
    logic [WD_W-1:0]              wd_nxt;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .pending   (pending),
        .last_grant(last_grant),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // The owner stops being busy in RESP, so it may queue its next operand there
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            busy[i] = pending[i] ||
                      ((owner == IDX_W'(i)) && ((state == ISSUE) || (state == WAIT)));
        end
    end

    always_comb begin
        do_grant    = any_valid && ((state == IDLE) || (state == RESP));
        accept      = req_start & ~busy;
        pending_nxt = (pending | accept) & ~(do_grant ? grant : '0);
        owner_oh    = N_REQ'(1) << owner;
        wd_nxt      = wd + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            xbuf         <= '0;
            owner        <= '0;
            last_grant   <= IDX_W'(N_REQ - 1);
            wd           <= '0;
            core_x_r     <= '0;
            core_start_r <= 1'b0;
            abort_r      <= 1'b0;
            req_done_r   <= '0;
            f_x_r        <= '0;
            req_err_r    <= '0;
            tflag_r      <= 1'b0;
        end else if (clk_en) begin
            pending <= pending_nxt;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (accept[i]) xbuf[i] <= req_x[i];
            end
            req_err_r    <= req_err_r | (req_start & busy);
            core_start_r <= 1'b0;
            abort_r      <= 1'b0;
            req_done_r   <= '0;

            if (do_grant) begin
                owner        <= grant_idx;
                last_grant   <= grant_idx;
                core_x_r     <= xbuf[grant_idx];
                core_start_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (do_grant) state <= ISSUE;
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd_nxt;
                    // A completion in the expiry cycle still delivers the real result
                    if (core.core_done) begin
                        f_x_r      <= core.core_f_x;
                        tflag_r    <= 1'b0;
                        req_done_r <= owner_oh;
                        state      <= RESP;
                    end else if (wd_nxt == WD_W'(TIMEOUT)) begin
                        f_x_r      <= DATA_W'(FX_NAN);
                        tflag_r    <= 1'b1;
                        abort_r    <= 1'b1;
                        req_done_r <= owner_oh;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    tflag_r <= 1'b0;
                    state   <= do_grant ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_done         = clk_en ? req_done_r : '0;
    assign f_x              = f_x_r;
    assign req_err          = req_err_r;
    assign timeout_flag     = tflag_r;
    assign core.core_start  = core_start_r & clk_en;
    assign core.core_x      = core_x_r;
    assign core.core_clk_en = clk_en;
    assign core.core_reset  = reset | abort_r;

endmodule

// File: tb/tb_fx_share_ctrl.sv
// Scoreboard bench for fx_share_ctrl with a 13-cycle x+1 core model.
module tb_fx_share_ctrl;
    import fx_share_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int          L  = 13;

    logic                     clk       = 1'b0;
    logic                     reset     = 1'b1;
    logic                     clk_en    = 1'b0;
    logic [NR-1:0]            req_start = '0;
    logic [NR-1:0][DW-1:0]    req_x     = '0;
    logic [NR-1:0]            req_done;
    logic [DW-1:0]            f_x;
    logic [NR-1:0]            req_err;
    logic                     timeout_flag;

    fx_share_ctrl_if #(.DATA_W(DW)) cif ();

    fx_share_ctrl #(
        .N_REQ  (NR),
        .DATA_W (DW),
        .TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .req_start   (req_start),
        .req_x       (req_x),
        .req_done    (req_done),
        .f_x         (f_x),
        .req_err     (req_err),
        .timeout_flag(timeout_flag),
        .core        (cif)
    );

    // Core model: done L cycles after start with x+1; hang swallows the result
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_cnt  = 0;
    logic [DW-1:0] m_x    = '0;
    logic [DW-1:0] m_f    = '0;
    logic          hang   = 1'b0;

    assign cif.core_done = m_done;
    assign cif.core_f_x  = m_f;

    always @(posedge clk) begin
        if (cif.core_reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (cif.core_clk_en) begin
            m_done <= 1'b0;
            if (cif.core_start) begin
                m_busy <= 1'b1;
                m_cnt  <= L - 1;
                m_x    <= cif.core_x;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    if (!hang) begin
                        m_done <= 1'b1;
                        m_f    <= m_x + 1;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] fx;
        logic        tf;
        int          cyc_at;
    } exp_t;

    exp_t exp_q[$];
    int   cs_q[$];
    int   rst_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input int idx, input logic [31:0] fx, input logic tf, input int at);
        exp_t e;
        e.idx    = idx;
        e.fx     = fx;
        e.tf     = tf;
        e.cyc_at = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cif.core_start) cs_q.push_back(cyc);
            if (cif.core_reset) rst_q.push_back(cyc);
            if (req_done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(req_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_onehot", 32'(req_done), 32'd1 << e.idx);
                    chk("done_f_x", f_x, e.fx);
                    chk("done_tflag", 32'(timeout_flag), 32'(e.tf));
                    chk("done_cycle", cyc, e.cyc_at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse();
        tick(1);
        req_start = '0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_start = '0;
        clk_en    = 1'b1;
        hang      = 1'b0;
        tick(3);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_core_start", 32'(cif.core_start), 32'd0);
        chk("rst_core_reset", 32'(cif.core_reset), 32'd1);
        chk("rst_req_err", 32'(req_err), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_f_x", f_x, 32'd0);
        reset = 1'b0;
        tick(2);
        exp_q.delete();
        cs_q.delete();
        rst_q.delete();
    endtask

    initial begin
        int c0;

        // Single uncontended request
        do_reset();
        c0 = cyc;
        req_x[0] = 32'h43800000; req_start[0] = 1'b1;
        expect_done(0, 32'h43800001, 1'b0, c0 + 16);
        start_pulse();
        tick(30);
        chk("single_drain", exp_q.size(), 0);
        chk("single_cs_count", cs_q.size(), 1);
        if (cs_q.size() >= 1) chk("single_cs_cycle", cs_q[0], c0 + 2);

        // Contention between 0, 1 and 3
        do_reset();
        c0 = cyc;
        req_x[0] = 32'h3F800000; req_x[1] = 32'h40000000; req_x[3] = 32'h40400000;
        req_start = 4'b1011;
        expect_done(0, 32'h3F800001, 1'b0, c0 + 16);
        expect_done(1, 32'h40000001, 1'b0, c0 + 31);
        expect_done(3, 32'h40400001, 1'b0, c0 + 46);
        start_pulse();
        tick(60);
        chk("cont_drain", exp_q.size(), 0);
        chk("cont_cs_count", cs_q.size(), 3);
        if (cs_q.size() == 3) begin
            chk("cont_cs_gap01", cs_q[1] - cs_q[0], 15);
            chk("cont_cs_gap13", cs_q[2] - cs_q[1], 15);
        end

        // Fairness: 0 and 2 keep re-requesting in their RESP cycles
        do_reset();
        c0 = cyc;
        req_x[0] = 32'h11110000; req_x[2] = 32'h22220000;
        req_start = 4'b0101;
        expect_done(0, 32'h11110001, 1'b0, c0 + 16);
        expect_done(2, 32'h22220001, 1'b0, c0 + 31);
        expect_done(0, 32'h33330001, 1'b0, c0 + 46);
        expect_done(2, 32'h44440001, 1'b0, c0 + 61);
        start_pulse();
        tick(15);
        req_x[0] = 32'h33330000; req_start[0] = 1'b1;
        start_pulse();
        tick(14);
        req_x[2] = 32'h44440000; req_start[2] = 1'b1;
        start_pulse();
        tick(40);
        chk("fair_drain", exp_q.size(), 0);

        // Busy error: second start while in flight is dropped
        do_reset();
        c0 = cyc;
        req_x[1] = 32'h40A00000; req_start[1] = 1'b1;
        expect_done(1, 32'h40A00001, 1'b0, c0 + 16);
        start_pulse();
        tick(4);
        req_x[1] = 32'h41200000; req_start[1] = 1'b1;
        start_pulse();
        tick(30);
        chk("busy_req_err", 32'(req_err), 32'h2);
        chk("busy_drain", exp_q.size(), 0);

        // Hung core aborts after the watchdog, next request served normally
        do_reset();
        hang = 1'b1;
        c0 = cyc;
        req_x[0] = 32'h12345678; req_x[2] = 32'h40E00000;
        req_start = 4'b0101;
        expect_done(0, 32'h7FC00000, 1'b1, c0 + 67);
        expect_done(2, 32'h40E00001, 1'b0, c0 + 82);
        start_pulse();
        tick(19);
        hang = 1'b0;
        tick(80);
        chk("hung_drain", exp_q.size(), 0);
        chk("hung_rst_count", rst_q.size(), 1);
        if (rst_q.size() >= 1) chk("hung_rst_cycle", rst_q[0], c0 + 67);
        chk("hung_cs_count", cs_q.size(), 2);
        if (cs_q.size() >= 2) chk("hung_cs_retry", cs_q[1], c0 + 68);

        // clk_en low for 10 cycles in WAIT delays completion by 10
        do_reset();
        c0 = cyc;
        req_x[0] = 32'h3F000000; req_start[0] = 1'b1;
        expect_done(0, 32'h3F000001, 1'b0, c0 + 26);
        start_pulse();
        tick(4);
        clk_en = 1'b0;
        tick(10);
        clk_en = 1'b1;
        tick(30);
        chk("clken_drain", exp_q.size(), 0);

        // Reset in WAIT discards the work and clears req_err
        do_reset();
        c0 = cyc;
        req_x[0] = 32'h40000000; req_start[0] = 1'b1;
        start_pulse();
        req_start[0] = 1'b1;
        start_pulse();
        tick(3);
        chk("rstmid_err_before", 32'(req_err), 32'h1);
        reset = 1'b1;
        tick(2);
        chk("rstmid_req_err", 32'(req_err), 32'd0);
        chk("rstmid_core_reset", 32'(cif.core_reset), 32'd1);
        reset = 1'b0;
        cs_q.delete();
        tick(30);
        chk("rstmid_no_start", cs_q.size(), 0);
        chk("rstmid_req_err_after", 32'(req_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
